// File: rtl/nand_arbiter.sv
// Two-requester arbiter feeding a single registered NAND datapath.
// Round-robin on contention; one result slot with valid/ready output handshake.
module nand_arbiter #(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid0,
    input  logic [n-1:0] A0,
    input  logic [n-1:0] B0,
    output logic         ready0,
    input  logic         valid1,
    input  logic [n-1:0] A1,
    input  logic [n-1:0] B1,
    output logic         ready1,
    output logic [n-1:0] F,
    output logic         out_valid,
    output logic         out_id,
    input  logic         out_ready,
    output logic [7:0]   op_count
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]   state;
    logic         prio;       // requester that wins when both are valid
    logic         slot_free;
    logic         grant0;
    logic         grant1;
    logic [n-1:0] op_a;
    logic [n-1:0] op_b;

    // Grants are held off during reset so nothing is accepted into a slot being cleared.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        grant0    = 1'b0;
        grant1    = 1'b0;
        slot_free = rst_n && ((state == IDLE) || out_ready);
        if (slot_free) begin
            if (valid0 && (!valid1 || (prio == 1'b0))) begin
                grant0 = 1'b1;
            end else if (valid1) begin
                grant1 = 1'b1;
            end
        end
    end

    assign ready0    = grant0;
    assign ready1    = grant1;
    assign op_a      = grant1 ? A1 : A0;
    assign op_b      = grant1 ? B1 : B0;
    assign out_valid = (state == BUSY);

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state    <= IDLE;
            F        <= '0;
            out_id   <= 1'b0;
            op_count <= 8'd0;
            prio     <= 1'b0;
        end else begin
            if ((state == BUSY) && out_ready) begin
                op_count <= op_count + 8'd1;
            end
            if (grant0 || grant1) begin
                state  <= BUSY;
                F      <= ~(op_a & op_b);
                out_id <= grant1;
                prio   <= grant0;
            end else if (out_ready) begin
                state <= IDLE;
            end
        end
    end

endmodule
